// File: rtl/dmi_bus_responder.sv
// Core-side DMI target: runs each DMI request as one register-bus access and returns a DMI response.
// Optional bus-wait timeout is enabled by defining DMI_RESP_TIMEOUT_EN.
module dmi_bus_responder #(
    parameter logic [6:0]  AddrLo        = 7'h04,
    parameter logic [6:0]  AddrHi        = 7'h7F,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dmi_clear_i,
    input  logic [40:0] dmi_req_i,
    input  logic        dmi_req_valid_i,
    output logic        dmi_req_ready_o,
    output logic [33:0] dmi_resp_o,
    output logic        dmi_resp_valid_o,
    input  logic        dmi_resp_ready_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [6:0]  bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    localparam logic [1:0] RESP_SUCCESS = 2'd0;
    localparam logic [1:0] RESP_FAILED  = 2'd2;

    localparam int unsigned CNT_W = 16;

    logic [1:0]  state_q, state_d;
    logic        discard_q, discard_d;
    logic        req_ready_d;
    logic        resp_valid_d;
    logic [33:0] resp_d;
    logic        bus_req_d;
    logic        bus_we_d;
    logic [6:0]  bus_addr_d;
    logic [31:0] bus_wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        timeout_c;

    logic [6:0]  req_addr;
    logic [1:0]  req_op;
    logic [31:0] req_data;
    logic        in_range;

    assign req_addr = dmi_req_i[40:34];
    assign req_op   = dmi_req_i[33:32];
    assign req_data = dmi_req_i[31:0];
    assign in_range = ({1'b0, req_addr} >= {1'b0, AddrLo}) &&
                      ({1'b0, req_addr} <= {1'b0, AddrHi});

`ifdef DMI_RESP_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TimeoutCycles - 1);
    assign timeout_c = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && (cnt_q == TIMEOUT_LAST);
`else
    assign timeout_c = 1'b0;
    if (TimeoutCycles == 0) begin : g_timeout_unused
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        discard_d    = discard_q;
        req_ready_d  = 1'b0;
        resp_valid_d = dmi_resp_valid_o;
        resp_d       = dmi_resp_o;
        bus_req_d    = 1'b0;
        bus_we_d     = bus_we_o;
        bus_addr_d   = bus_addr_o;
        bus_wdata_d  = bus_wdata_o;
        cnt_d        = '0;

        case (state_q)
            S_IDLE: begin
                if (dmi_clear_i || !dmi_req_valid_i) begin
                    req_ready_d = 1'b1;
                end else if (req_op == OP_NOP) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_d       = {32'h0, RESP_SUCCESS};
                end else if ((req_op != OP_READ && req_op != OP_WRITE) || !in_range) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_d       = {32'h0, RESP_FAILED};
                end else begin
                    state_d     = S_ISSUE;
                    discard_d   = 1'b0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = (req_op == OP_WRITE);
                    bus_addr_d  = req_addr;
                    bus_wdata_d = req_data;
                end
            end
            S_ISSUE, S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (timeout_c) begin
                    if (dmi_clear_i || discard_q) begin
                        state_d     = S_IDLE;
                        req_ready_d = 1'b1;
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_d       = {32'h0, RESP_FAILED};
                    end
                end else if (state_q == S_ISSUE) begin
                    // A grant commits the bus; a coincident clear must drain the completion
                    if (bus_gnt_i) begin
                        state_d   = S_WAIT;
                        discard_d = dmi_clear_i;
                    end else if (dmi_clear_i) begin
                        state_d     = S_IDLE;
                        req_ready_d = 1'b1;
                    end else begin
                        bus_req_d = 1'b1;
                    end
                end else if (bus_rvalid_i) begin
                    if (dmi_clear_i || discard_q) begin
                        state_d     = S_IDLE;
                        req_ready_d = 1'b1;
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_d[1:0]  = bus_err_i ? RESP_FAILED : RESP_SUCCESS;
                        resp_d[33:2] = (!bus_we_o && !bus_err_i) ? bus_rdata_i : 32'h0;
                    end
                end else if (dmi_clear_i) begin
                    discard_d = 1'b1;
                end
            end
            default: begin
                if (dmi_clear_i || dmi_resp_ready_i) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    resp_d       = '0;
                    req_ready_d  = 1'b1;
                end
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= S_IDLE;
            discard_q        <= 1'b0;
            cnt_q            <= '0;
            dmi_req_ready_o  <= 1'b1;
            dmi_resp_valid_o <= 1'b0;
            dmi_resp_o       <= '0;
            bus_req_o        <= 1'b0;
            bus_we_o         <= 1'b0;
            bus_addr_o       <= '0;
            bus_wdata_o      <= '0;
        end else begin
            state_q          <= state_d;
            discard_q        <= discard_d;
            cnt_q            <= cnt_d;
            dmi_req_ready_o  <= req_ready_d;
            dmi_resp_valid_o <= resp_valid_d;
            dmi_resp_o       <= resp_d;
            bus_req_o        <= bus_req_d;
            bus_we_o         <= bus_we_d;
            bus_addr_o       <= bus_addr_d;
            bus_wdata_o      <= bus_wdata_d;
        end
    end

endmodule
